// File: rtl/tmds_pkg.sv
// Definitions shared by the TMDS transmit encoder and receive decoder so both
// ends agree on the word width, the control tokens and the alignment states.
package tmds_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    function automatic logic is_ctrl_token(input logic [WORD_W-1:0] w);
        return (w == CTRL_TOKEN_00) || (w == CTRL_TOKEN_01) ||
               (w == CTRL_TOKEN_10) || (w == CTRL_TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Word stream from the deserializer and the decoded results of one TMDS channel.
interface tmds_channel_decoder_if;
    import tmds_pkg::*;

    logic [WORD_W-1:0] raw_word;
    logic [7:0]        vd;
    logic [1:0]        cd;
    logic              vde;
    logic              locked;
    logic [3:0]        bit_offset;
    logic              decode_err;

    modport master (
        output raw_word,
        input  vd, cd, vde, locked, bit_offset, decode_err
    );

    modport slave (
        input  raw_word,
        output vd, cd, vde, locked, bit_offset, decode_err
    );

endinterface

// File: rtl/tmds_word_decode.sv
// Purely combinational decode of one aligned TMDS word into video data or a
// control code, with flags for control tokens and reserved data forms.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [7:0]        vd,
    output logic [1:0]        cd,
    output logic              is_token,
    output logic              reserved
);

    logic [7:0] d;

    always_comb begin
        is_token = is_ctrl_token(word);
        cd = 2'b00;
        case (word)
            CTRL_TOKEN_01: cd = 2'b01;
            CTRL_TOKEN_10: cd = 2'b10;
            CTRL_TOKEN_11: cd = 2'b11;
            default:       cd = 2'b00;
        endcase
        d = word[9] ? ~word[7:0] : word[7:0];
        vd = '0;
        vd[0] = d[0];
        // bit 8 says whether the encoder chained with XOR (1) or XNOR (0)
        for (int i = 1; i < 8; i++) begin
            vd[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        reserved = !is_token && (word[9:8] == 2'b11) &&
                   ((word[7:0] == 8'h00) || (word[7:0] == 8'hFF));
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds word alignment from runs of control tokens,
// then decodes aligned words to video data or control codes.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS = 8,
    parameter int TIMEOUT     = 2048
)(
    input logic             clk_pixel,
    input logic             rst_n,
    tmds_channel_decoder_if.slave bus
);

    localparam int CNT_W   = $clog2(LOCK_TOKENS + 1);
    localparam int SINCE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LOCK_CNT    = CNT_W'(LOCK_TOKENS);
    localparam logic [SINCE_W-1:0] TIMEOUT_CNT = SINCE_W'(TIMEOUT);
    localparam logic [SINCE_W-1:0] SINCE_MAX   = '1;

    logic [WORD_W-1:0]   r0, r1;
    logic [2*WORD_W-1:0] window;
    logic [WORD_W-1:0]   aligned;
    logic                match_any;
    logic [3:0]          match_off;

    align_state_t        state, state_nxt;
    logic [3:0]          offset, offset_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SINCE_W-1:0]  since, since_nxt;

    logic [7:0]          vd_q, vd_nxt;
    logic [1:0]          cd_q, cd_nxt;
    logic                vde_q, vde_nxt;
    logic                err_q, err_nxt;

    logic [7:0]          dec_vd;
    logic [1:0]          dec_cd;
    logic                dec_token;
    logic                dec_reserved;

    // Older word sits in the low half so the serial bit order runs upward.
    assign window = {r0, r1};

    always_comb begin
        aligned = window[WORD_W-1:0];
        for (int k = 1; k < WORD_W; k++) begin
            if (offset == 4'(k)) aligned = window[k +: WORD_W];
        end
    end

    // Scan downward so the lowest matching offset wins.
    always_comb begin
        match_any = 1'b0;
        match_off = 4'd0;
        for (int k = WORD_W - 1; k >= 0; k--) begin
            if (is_ctrl_token(window[k +: WORD_W])) begin
                match_any = 1'b1;
                match_off = 4'(k);
            end
        end
    end

    tmds_word_decode u_decode (
        .word     (aligned),
        .vd       (dec_vd),
        .cd       (dec_cd),
        .is_token (dec_token),
        .reserved (dec_reserved)
    );

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        cnt_nxt    = cnt;
        since_nxt  = since;
        vd_nxt     = vd_q;
        cd_nxt     = cd_q;
        vde_nxt    = 1'b0;
        err_nxt    = 1'b0;
        if (state == SEARCH) begin
            vd_nxt = '0;
            cd_nxt = '0;
            if (match_any) begin
                if (match_off == offset) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    offset_nxt = match_off;
                    cnt_nxt    = CNT_W'(1);
                end
            end
            if (cnt_nxt == LOCK_CNT) begin
                state_nxt = LOCKED;
                since_nxt = '0;
            end
        end else begin
            if (dec_token) begin
                cd_nxt    = dec_cd;
                since_nxt = '0;
            end else begin
                vde_nxt = 1'b1;
                vd_nxt  = dec_vd;
                err_nxt = dec_reserved;
                if (since != SINCE_MAX) since_nxt = since + 1'b1;
                // Still decode this word; blanking of outputs starts next cycle.
                if (since_nxt == TIMEOUT_CNT) begin
                    state_nxt = SEARCH;
                    cnt_nxt   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r0     <= '0;
            r1     <= '0;
            state  <= SEARCH;
            offset <= '0;
            cnt    <= '0;
            since  <= '0;
            vd_q   <= '0;
            cd_q   <= '0;
            vde_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            r0     <= bus.raw_word;
            r1     <= r0;
            state  <= state_nxt;
            offset <= offset_nxt;
            cnt    <= cnt_nxt;
            since  <= since_nxt;
            vd_q   <= vd_nxt;
            cd_q   <= cd_nxt;
            vde_q  <= vde_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.vd         = vd_q;
    assign bus.cd         = cd_q;
    assign bus.vde        = vde_q;
    assign bus.decode_err = err_q;
    assign bus.bit_offset = offset;
    assign bus.locked     = (state == LOCKED);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a decode table at offset 0 plus
// hand-built sequences for rotation, candidate restart, timeout and reset.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    logic clk_pixel = 1'b0;
    logic rst_n;

    tmds_channel_decoder_if bus_if ();

    tmds_channel_decoder #(
        .LOCK_TOKENS (8),
        .TIMEOUT     (2048)
    ) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .bus       (bus_if)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [9:0] raw;
        logic [7:0] vd;
        logic [1:0] cd;
        logic       vde;
        logic       locked;
        logic       err;
    } vec_t;

    vec_t       vecs [20];
    int         errors = 0;
    int         checks = 0;
    logic [9:0] prev_word;

    task automatic checkValue(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_vd,
                               input logic [1:0] exp_cd, input logic exp_vde,
                               input logic exp_locked, input logic [3:0] exp_off,
                               input logic exp_err, input bit check_off);
        checkValue({tag, ".vd"}, bus_if.vd, exp_vd);
        checkValue({tag, ".cd"}, 8'(bus_if.cd), 8'(exp_cd));
        checkValue({tag, ".vde"}, 8'(bus_if.vde), 8'(exp_vde));
        checkValue({tag, ".locked"}, 8'(bus_if.locked), 8'(exp_locked));
        checkValue({tag, ".decode_err"}, 8'(bus_if.decode_err), 8'(exp_err));
        if (check_off) checkValue({tag, ".bit_offset"}, 8'(bus_if.bit_offset), 8'(exp_off));
    endtask

    // Drive one raw word and return at the following negedge.
    task automatic applyStimulus(input logic [9:0] raw);
        bus_if.raw_word = raw;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
    endtask

    // Emit one word of a serial stream delayed by k bits.
    function automatic logic [9:0] shiftWord(input logic [9:0] cur, input logic [9:0] prev,
                                             input int k);
        logic [19:0] pair;
        pair = {cur, prev} >> (10 - k);
        return pair[9:0];
    endfunction

    task automatic sendShifted(input logic [9:0] cur, input int k);
        applyStimulus(shiftWord(cur, prev_word, k));
        prev_word = cur;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus_if.raw_word = '0;
        prev_word = '0;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        rst_n = 1'b1;
    endtask

    task automatic setVec(input int idx, input logic [9:0] raw, input logic [7:0] vd,
                          input logic [1:0] cd, input logic vde, input logic locked,
                          input logic err);
        vecs[idx].raw    = raw;
        vecs[idx].vd     = vd;
        vecs[idx].cd     = cd;
        vecs[idx].vde    = vde;
        vecs[idx].locked = locked;
        vecs[idx].err    = err;
    endtask

    initial begin
        // Outputs after step j reflect the word driven at step j-2.
        for (int i = 0; i < 8; i++) setVec(i, CTRL_TOKEN_00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        setVec(8,  10'h100, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        setVec(9,  10'h200, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
        setVec(10, 10'h0AB, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0);
        setVec(11, 10'h2C3, 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0);
        setVec(12, 10'h1F0, 8'hFF, 2'b01, 1'b0, 1'b1, 1'b0);
        setVec(13, 10'h3FF, 8'hBA, 2'b01, 1'b1, 1'b1, 1'b0);
        setVec(14, 10'h300, 8'h10, 2'b01, 1'b1, 1'b1, 1'b0);
        setVec(15, 10'h2FF, 8'h00, 2'b01, 1'b1, 1'b1, 1'b1);
        setVec(16, 10'h2AB, 8'h01, 2'b01, 1'b1, 1'b1, 1'b1);
        setVec(17, 10'h154, 8'hFE, 2'b01, 1'b1, 1'b1, 1'b0);
        setVec(18, 10'h100, 8'hFE, 2'b11, 1'b0, 1'b1, 1'b0);
        setVec(19, 10'h100, 8'hFE, 2'b10, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0;
        bus_if.raw_word = '0;
        prev_word = '0;
        @(negedge clk_pixel);

        $display("[TB] reset with random input");
        for (int i = 0; i < 4; i++) begin
            bus_if.raw_word = 10'($urandom);
            @(negedge clk_pixel);
            checkOutput($sformatf("in_reset%0d", i), 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(10'($urandom));
            checkOutput($sformatf("post_reset%0d", i), 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        $display("[TB] offset 0 lock and decode table");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].raw);
            checkOutput($sformatf("table%0d", i), vecs[i].vd, vecs[i].cd, vecs[i].vde,
                        vecs[i].locked, 4'd0, vecs[i].err, 1'b1);
        end

        $display("[TB] stream rotated by 3 bits");
        doReset();
        for (int i = 0; i < 13; i++) begin
            if (i < 9)       sendShifted(CTRL_TOKEN_11, 3);
            else if (i == 10) sendShifted(10'h200, 3);
            else             sendShifted(10'h100, 3);
            if (i == 8)  checkOutput("rot_pre_lock", 8'h00, 2'b00, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
            if (i == 9)  checkOutput("rot_lock", 8'h00, 2'b00, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
            if (i == 10) checkOutput("rot_token", 8'h00, 2'b11, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
            if (i == 11) checkOutput("rot_data00", 8'h00, 2'b11, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
            if (i == 12) checkOutput("rot_dataFF", 8'hFF, 2'b11, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        end

        $display("[TB] candidate restart from offset 2 to offset 6");
        doReset();
        for (int i = 0; i < 17; i++) begin
            if (i < 5)       sendShifted(CTRL_TOKEN_00, 2);
            else if (i < 7)  sendShifted(10'h000, 2);
            else if (i < 15) sendShifted(CTRL_TOKEN_00, 6);
            else             sendShifted(10'h000, 6);
            if (i == 6)  checkOutput("restart_cand2", 8'h00, 2'b00, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
            if (i == 9)  checkOutput("restart_cand6", 8'h00, 2'b00, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1);
            if (i == 15) checkOutput("restart_7tok", 8'h00, 2'b00, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1);
            if (i == 16) checkOutput("restart_lock", 8'h00, 2'b00, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
        end

        $display("[TB] timeout after 2048 data words");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(CTRL_TOKEN_00);
        for (int n = 1; n <= 2051; n++) begin
            applyStimulus(10'h100);
            if (n == 2)    checkValue("to_locked", 8'(bus_if.locked), 8'd1);
            if (n == 2049) checkOutput("to_word2047", 8'h00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
            if (n == 2050) checkOutput("to_word2048", 8'h00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
            if (n == 2051) checkOutput("to_forced", 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        end

        $display("[TB] token at word 2047 keeps lock");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(CTRL_TOKEN_00);
        for (int n = 1; n <= 2051; n++) begin
            applyStimulus((n == 2047) ? CTRL_TOKEN_00 : 10'h100);
            if (n == 2049) checkOutput("keep_token", 8'h00, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
            if (n == 2050) checkOutput("keep_word2048", 8'h00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
            if (n == 2051) checkOutput("keep_after", 8'h00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        end

        $display("[TB] reset pulse while locked");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset", 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk_pixel);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i < 8) ? CTRL_TOKEN_00 : 10'h100);
            if (i == 1) checkOutput("relock_flushed", 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
            if (i == 8) checkValue("relock_7tok", 8'(bus_if.locked), 8'd0);
            if (i == 9) checkValue("relock_8tok", 8'(bus_if.locked), 8'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
